// File: rtl/brcomp_iter.sv
// brcomp_iter -- iterative branch comparator for the RV32I execute stage.
//
// Compares two XLEN-bit operands CHUNK bits per cycle, most significant slice
// first, and stops at the first slice that differs. Signed compares are turned
// into unsigned ones by inverting the operand sign bits at capture. The
// less/equal flags are registered and sit behind valid/ready handshakes on
// both sides, which keeps the compare off the critical path.
//
// Parameters:
//   XLEN  - operand width (default 32)
//   CHUNK - bits compared per cycle (default 8). XLEN must be a multiple of
//           CHUNK. CHUNK == XLEN gives a single-cycle compare.
//
// Ports:
//   clk, rst            - clock (rising edge), synchronous active-high reset
//   in_valid / in_ready - operand handshake; in_ready is high only in IDLE
//   rs1_data, rs2_data  - operands A and B
//   br_un               - 1 = unsigned compare, 0 = signed compare
//   out_valid/out_ready - result handshake
//   less, equal         - A < B under the captured mode, A == B
//
// Optional feature (macro BRCOMP_BRANCH_EN):
//   funct3   - input, branch funct3, captured at the accept edge
//   br_taken - output, branch decision registered together with less/equal
//              (reset 0)

module brcomp_iter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            br_un,
`ifdef BRCOMP_BRANCH_EN
    input  logic [2:0]      funct3,
    output logic            br_taken,
`endif
    output logic            out_valid,
    input  logic            out_ready,
    output logic            less,
    output logic            equal
);

    localparam int unsigned N    = XLEN / CHUNK;
    localparam int unsigned IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [N-1:0][CHUNK-1:0]     a_q, a_d;
    logic [N-1:0][CHUNK-1:0]     b_q, b_d;
    logic [IDXW-1:0]             idx_q, idx_d;
    logic                        less_q, less_d;
    logic                        equal_q, equal_d;

    logic [XLEN-1:0]             a_in, b_in;
    logic [CHUNK-1:0]            a_sl, b_sl;

`ifdef BRCOMP_BRANCH_EN
    logic [2:0]                  f3_q, f3_d;
    logic                        taken_q, taken_d;

    function automatic logic branch_decode(input logic [2:0] f3,
                                           input logic       lt,
                                           input logic       eq);
        logic t;
        t = 1'b0;
        case (f3)
            3'b000:  t = eq;
            3'b001:  t = !eq;
            3'b100:  t = lt;
            3'b101:  t = !lt;
            3'b110:  t = lt;
            3'b111:  t = !lt;
            default: t = 1'b0;
        endcase
        return t;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        less_d  = less_q;
        equal_d = equal_q;
`ifdef BRCOMP_BRANCH_EN
        f3_d    = f3_q;
        taken_d = taken_q;
`endif

        // Flipping the sign bit maps two's-complement order onto unsigned
        // order, so the slice compare below is always unsigned.
        a_in           = rs1_data;
        b_in           = rs2_data;
        a_in[XLEN-1]   = rs1_data[XLEN-1] ^ ~br_un;
        b_in[XLEN-1]   = rs2_data[XLEN-1] ^ ~br_un;

        a_sl = a_q[idx_q];
        b_sl = b_q[idx_q];

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    idx_d   = IDXW'(N - 1);
                    state_d = BUSY;
`ifdef BRCOMP_BRANCH_EN
                    f3_d    = funct3;
`endif
                end
            end
            BUSY: begin
                if (a_sl != b_sl) begin
                    less_d  = (a_sl < b_sl);
                    equal_d = 1'b0;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    less_d  = 1'b0;
                    equal_d = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - 1'b1;
                end
`ifdef BRCOMP_BRANCH_EN
                if (state_d == DONE) begin
                    taken_d = branch_decode(f3_q, less_d, equal_d);
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            less_q  <= 1'b0;
            equal_q <= 1'b0;
`ifdef BRCOMP_BRANCH_EN
            f3_q    <= '0;
            taken_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            less_q  <= less_d;
            equal_q <= equal_d;
`ifdef BRCOMP_BRANCH_EN
            f3_q    <= f3_d;
            taken_q <= taken_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign less      = less_q;
    assign equal     = equal_q;
`ifdef BRCOMP_BRANCH_EN
    assign br_taken  = taken_q;
`endif

endmodule

// File: tb/tb_brcomp_iter.sv
module tb_brcomp_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        br_un;
    logic        out_valid;
    logic        out_ready;
    logic        less;
    logic        equal;
`ifdef BRCOMP_BRANCH_EN
    logic [2:0]  funct3;
    logic        br_taken;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    brcomp_iter #(
        .XLEN  (32),
        .CHUNK (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .br_un     (br_un),
`ifdef BRCOMP_BRANCH_EN
        .funct3    (funct3),
        .br_taken  (br_taken),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .less      (less),
        .equal     (equal)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, wait for result, optional back-pressure,
    // output handshake. Latency is counted in cycles after the accept edge.
    task automatic run_cmp(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic un, input logic [2:0] f3, input int exp_k,
                           input logic exp_less, input logic exp_eq,
                           input logic exp_taken, input int hold);
        int k;
        check({tag, ":in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        rs1_data = a;
        rs2_data = b;
        br_un    = un;
`ifdef BRCOMP_BRANCH_EN
        funct3   = f3;
`endif
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        rs1_data = ~a;
        rs2_data = ~b;
        br_un    = ~un;
`ifdef BRCOMP_BRANCH_EN
        funct3   = ~f3;
`endif
        k = 0;
        while (!out_valid && k < 40) begin
            check({tag, ":in_ready_busy"}, {31'd0, in_ready}, 32'd0);
            step();
            k++;
        end
        check({tag, ":latency"}, k, exp_k);
        check({tag, ":less"}, {31'd0, less}, {31'd0, exp_less});
        check({tag, ":equal"}, {31'd0, equal}, {31'd0, exp_eq});
`ifdef BRCOMP_BRANCH_EN
        check({tag, ":br_taken"}, {31'd0, br_taken}, {31'd0, exp_taken});
`else
        if (exp_taken === 1'bx) $display("unexpected");
`endif
        if (f3 === 3'bxxx) $display("unexpected");
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            step();
            check({tag, ":hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, ":hold_less"}, {31'd0, less}, {31'd0, exp_less});
            check({tag, ":hold_equal"}, {31'd0, equal}, {31'd0, exp_eq});
            check({tag, ":hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, ":post_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ":post_in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, ":post_less_kept"}, {31'd0, less}, {31'd0, exp_less});
        check({tag, ":post_equal_kept"}, {31'd0, equal}, {31'd0, exp_eq});
    endtask

    initial begin
        int k;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rs1_data  = '0;
        rs2_data  = '0;
        br_un     = 1'b0;
`ifdef BRCOMP_BRANCH_EN
        funct3    = 3'b000;
`endif
        step();
        step();
        rst = 1'b0;
        step();
        check("reset:out_valid", {31'd0, out_valid}, 32'd0);
        check("reset:less", {31'd0, less}, 32'd0);
        check("reset:equal", {31'd0, equal}, 32'd0);
        check("reset:in_ready", {31'd0, in_ready}, 32'd1);
`ifdef BRCOMP_BRANCH_EN
        check("reset:br_taken", {31'd0, br_taken}, 32'd0);
`endif

        //       tag         rs1           rs2           un    f3      k  lt    eq    taken hold
        run_cmp("signed_m1", 32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b100, 1, 1'b1, 1'b0, 1'b1, 0);
        run_cmp("unsig_m1",  32'hFFFFFFFF, 32'h00000001, 1'b1, 3'b110, 1, 1'b0, 1'b0, 1'b0, 0);
        run_cmp("eq_4cyc",   32'h12345678, 32'h12345678, 1'b1, 3'b000, 4, 1'b0, 1'b1, 1'b1, 0);
        run_cmp("lsb_diff",  32'h00000010, 32'h00000011, 1'b1, 3'b111, 4, 1'b1, 1'b0, 1'b0, 5);
        run_cmp("slice2_lt", 32'h12340000, 32'h12350000, 1'b1, 3'b110, 2, 1'b1, 1'b0, 1'b1, 0);
        run_cmp("slice3_gt", 32'h00AB0000, 32'h00AA0000, 1'b0, 3'b101, 2, 1'b0, 1'b0, 1'b1, 0);
        run_cmp("bge_minmax",32'h80000000, 32'h7FFFFFFF, 1'b0, 3'b101, 1, 1'b1, 1'b0, 1'b0, 0);
        run_cmp("bltu_minmax",32'h80000000,32'h7FFFFFFF, 1'b1, 3'b110, 1, 1'b0, 1'b0, 1'b0, 0);
        run_cmp("bne_eq7",   32'h00000007, 32'h00000007, 1'b0, 3'b001, 4, 1'b0, 1'b1, 1'b0, 0);
        run_cmp("neg_neg",   32'hFFFFFF80, 32'hFFFFFF7F, 1'b0, 3'b010, 4, 1'b0, 1'b0, 1'b0, 0);
        run_cmp("lt_for_rst",32'h00000010, 32'h00000011, 1'b1, 3'b100, 4, 1'b1, 1'b0, 1'b1, 0);

        // Reset two cycles after accept: the compare must be discarded.
        check("rst_mid:in_ready", {31'd0, in_ready}, 32'd1);
        rs1_data = 32'h0;
        rs2_data = 32'h0;
        br_un    = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid:out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid:less", {31'd0, less}, 32'd0);
        check("rst_mid:equal", {31'd0, equal}, 32'd0);
        check("rst_mid:in_ready", {31'd0, in_ready}, 32'd1);
        k = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) k++;
            step();
        end
        check("rst_mid:no_result", k, 0);

        run_cmp("after_rst", 32'h00000005, 32'h00000003, 1'b1, 3'b110, 4, 1'b0, 1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
